// File: rtl/alu_issue_if.sv
// Upstream instruction and downstream result handshakes of the ALU issue stage.
// The design drives the slave side; an upstream/downstream agent uses master.
interface alu_issue_if #(
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [5:0]       in_opcode;
    logic [5:0]       in_funct;
    logic [31:0]      in_rs_val;
    logic [31:0]      in_rt_val;
    logic [15:0]      in_imm;
    logic [4:0]       in_rd;

    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic             out_zero;
    logic [4:0]       out_rd;
    logic             out_illegal;
    logic [CNT_W-1:0] retired;

    modport master (
        output in_valid, in_opcode, in_funct, in_rs_val, in_rt_val, in_imm, in_rd,
        input  in_ready,
        input  out_valid, out_result, out_zero, out_rd, out_illegal, retired,
        output out_ready
    );

    modport slave (
        input  in_valid, in_opcode, in_funct, in_rs_val, in_rt_val, in_imm, in_rd,
        output in_ready,
        output out_valid, out_result, out_zero, out_rd, out_illegal, retired,
        input  out_ready
    );
endinterface

// File: rtl/alu_issue.sv
// Two-stage issue pipeline: S1 decodes into registered ALU operands, S2 captures
// the external ALU result and presents it downstream with a valid/ready handshake.
module alu_issue #(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    alu_issue_if.slave        bus,
    output logic [31:0]       alu_a,
    output logic [31:0]       alu_b,
    output logic [3:0]        alu_op,
    input  logic [31:0]       alu_r,
    input  logic              alu_zf
);
    localparam logic [3:0] OP_ILL = 4'b1111;

    logic             s1_valid;
    logic [4:0]       s1_tag;
    logic             s1_ill;
    logic             s2_valid;
    logic [31:0]      s2_result;
    logic             s2_zero;
    logic [4:0]       s2_tag;
    logic             s2_ill;
    logic [CNT_W-1:0] retired_q;

    logic             s2_free;
    logic             s1_load;
    logic             s2_load;

    logic [31:0]      dec_a;
    logic [31:0]      dec_b;
    logic [3:0]       dec_op;
    logic [4:0]       dec_tag;
    logic             dec_ill;
    logic [31:0]      imm_sext;
    logic [31:0]      imm_zext;

    assign s2_free     = !s2_valid || bus.out_ready;
    assign bus.in_ready = !flush && (!s1_valid || s2_free);
    assign s1_load     = bus.in_valid && bus.in_ready;
    assign s2_load     = !flush && s1_valid && s2_free;

    assign imm_sext = {{16{bus.in_imm[15]}}, bus.in_imm};
    assign imm_zext = {16'h0000, bus.in_imm};

    always_comb begin
        dec_a   = '0;
        dec_b   = '0;
        dec_op  = OP_ILL;
        dec_tag = '0;
        dec_ill = 1'b0;
        case (bus.in_opcode)
            6'b000000: begin
                dec_b   = bus.in_rt_val;
                dec_tag = bus.in_rd;
                case (bus.in_funct)
                    6'b100100: dec_op = 4'b0000;
                    6'b100101: dec_op = 4'b0001;
                    6'b100000: dec_op = 4'b0010;
                    6'b100010: dec_op = 4'b0110;
                    6'b101010: dec_op = 4'b0111;
                    6'b100111: dec_op = 4'b0101;
                    default:   dec_ill = 1'b1;
                endcase
            end
            6'b001000: begin dec_op = 4'b0010; dec_b = imm_sext; dec_tag = bus.in_rd; end
            6'b001010: begin dec_op = 4'b0111; dec_b = imm_sext; dec_tag = bus.in_rd; end
            6'b001100: begin dec_op = 4'b0000; dec_b = imm_zext; dec_tag = bus.in_rd; end
            6'b001101: begin dec_op = 4'b0001; dec_b = imm_zext; dec_tag = bus.in_rd; end
            // BEQ is a subtract whose only useful product is the zero flag
            6'b000100: begin dec_op = 4'b0110; dec_b = bus.in_rt_val; end
            default:   dec_ill = 1'b1;
        endcase
        if (dec_ill) begin
            dec_op  = OP_ILL;
            dec_b   = '0;
            dec_tag = '0;
        end else begin
            dec_a   = bus.in_rs_val;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_op   <= OP_ILL;
            s1_tag   <= '0;
            s1_ill   <= 1'b0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (s1_load) begin
            s1_valid <= 1'b1;
            alu_a    <= dec_a;
            alu_b    <= dec_b;
            alu_op   <= dec_op;
            s1_tag   <= dec_tag;
            s1_ill   <= dec_ill;
        end else if (s2_free) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid  <= 1'b0;
            s2_result <= '0;
            s2_zero   <= 1'b0;
            s2_tag    <= '0;
            s2_ill    <= 1'b0;
        end else if (flush) begin
            s2_valid  <= 1'b0;
        end else if (s2_load) begin
            s2_valid  <= 1'b1;
            s2_result <= alu_r;
            s2_zero   <= alu_zf;
            s2_tag    <= s1_tag;
            s2_ill    <= s1_ill;
        end else if (bus.out_ready) begin
            s2_valid  <= 1'b0;
        end
    end

    // Counts every completed transfer, including one that coincides with a flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_q <= '0;
        end else if (s2_valid && bus.out_ready) begin
            retired_q <= retired_q + 1'b1;
        end
    end

    assign bus.out_valid   = s2_valid;
    assign bus.out_result  = s2_result;
    assign bus.out_zero    = s2_zero;
    assign bus.out_rd      = s2_tag;
    assign bus.out_illegal = s2_ill;
    assign bus.retired     = retired_q;
endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter: CNT_W, 16, width of the retired-operation counter.
REQ-002 clk  in  1  single clock for all state; rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 flush  in  1  synchronous pipeline clear.
REQ-005 in_valid / in_ready  in / out  1 / 1  upstream handshake.
REQ-006 in_opcode, in_funct  in  6 each  instruction fields.
REQ-007 in_rs_val, in_rt_val  in  32 each  register operands.
REQ-008 in_imm  in  16  immediate.
REQ-009 in_rd  in  5  destination tag.
REQ-010 alu_a, alu_b  out  32 each  ALU operands, driven from stage-1 registers.
REQ-011 alu_op  out  4  ALU operation code.
REQ-012 alu_r  in  32  ALU result, combinational from alu_a/alu_b/alu_op.
REQ-013 alu_zf  in  1  ALU zero flag.
REQ-014 out_valid / out_ready  out / in  1 / 1  downstream handshake.
REQ-015 out_result  out  32; out_zero  out  1; out_rd  out  5; out_illegal  out  1.
REQ-016 retired  out  CNT_W  count of completed output transfers.

Function
REQ-017 Two-stage pipeline shall be used: S1 (decode register driving the ALU), S2 (result register driving out_*).
REQ-018 Decode, R-type (opcode 000000), shall map funct to op/B=rt: 100100->0000 AND, 100101->0001 OR, 100000->0010 ADD, 100010->0110 SUB, 101010->0111 SLT, 100111->0101 NOR.
REQ-019 Decode, I-type, shall be: 001000 ADDI->0010, B=sign-ext imm; 001010 SLTI->0111, sign-ext; 001100 ANDI->0000, zero-ext; 001101 ORI->0001, zero-ext; B written into S1, rd tag = in_rt_val not used, tag = in_rd.
REQ-020 000100 BEQ shall map to op 0110, B=rt, tag forced to 0.
REQ-021 A shall always be in_rs_val.
REQ-022 Any other opcode/funct shall map to op 1111, A=B=0, tag 0, illegal=1; it shall still flow through and be counted.
REQ-023 S1 shall load on in_valid && in_ready.
REQ-024 in_ready shall be !s1_valid || s2_free, where s2_free = !s2_valid || out_ready (combinational).
REQ-025 S2 shall load alu_r, alu_zf, tag and illegal when s1_valid && s2_free; S1 shall empty in the same cycle unless refilled.
REQ-026 Latency: accepted input shall appear on out_* 2 cycles later when unstalled; throughput shall be 1 per cycle.
REQ-027 While out_valid && !out_ready, out_* shall hold stable and S1 shall hold, with in_ready low if S1 is full.
REQ-028 Simultaneous S2 drain and refill in one cycle shall lose no data.
REQ-029 retired shall increment on out_valid && out_ready, wrap modulo 2^CNT_W, and not clear on flush.
REQ-030 flush shall clear s1_valid and s2_valid next edge, override loads that cycle, and force in_ready=0 that cycle.
REQ-031 The ALU shall see registered operands only; no combinational path shall run from in_* to alu_*.

Reset
REQ-032 On rst high, immediately shall hold: s1_valid=s2_valid=0, out_valid=0, out_result=0, out_zero=0, out_rd=0, out_illegal=0, retired=0, alu_a=alu_b=0, alu_op=1111.
REQ-033 On rst mid-transfer, in-flight operations shall be discarded, with no partial output.
REQ-034 in_ready shall be 1 in the first cycle after rst deasserts.

Verification
REQ-035 ADD rs=5, rt=7, rd=3, out_ready=1 -> 2 cycles later out_valid=1, out_result=12, out_zero=0, out_rd=3, retired=1.
REQ-036 ADDI rs=1, imm=0xFFFF -> out_result=0, out_zero=1; ORI rs=0, imm=0xFFFF -> out_result=0x0000FFFF.
REQ-037 BEQ rs=rt=0x1234 -> out_zero=1, out_rd=0; SLT rs=2, rt=9 -> out_result=1.
REQ-038 Back-to-back stream of 4 ops with out_ready low 3 cycles after the first output -> output held stable, in_ready falls after S1 fills, all 4 results arrive in order, retired=4.
REQ-039 Illegal opcode 111111 -> out_illegal=1, out_result=0, retired increments.
REQ-040 flush, and separately rst, asserted with both stages full -> no out_valid, retired unchanged (flush) or 0 (rst).
